// File: rtl/fp_int_acc_stream_if.sv
// Stream interface for fp_int_acc_stream: term input beats, reference exponent
// configuration and the batch result handshake.
interface fp_int_acc_stream_if #(
    parameter int MANT_W = 14,
    parameter int EXP_W  = 5,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
);
    logic [EXP_W-1:0]  cfg_exp_set;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [EXP_W-1:0]  out_exp;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output cfg_exp_set, in_valid, in_sign, in_exp, in_mant, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_exp, out_count, out_ovf
    );

    modport slave (
        input  cfg_exp_set, in_valid, in_sign, in_exp, in_mant, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_exp, out_count, out_ovf
    );
endinterface

// File: rtl/fp_int_acc_stream.sv
// Streaming exponent-aligned fixed-point accumulator (align stage + accumulate stage).
// Optional feature macro: ACC_SATURATE_EN (clamp oversized terms, saturate the sum).
module fp_int_acc_stream #(
    parameter int MANT_W = 14,
    parameter int EXP_W  = 5,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_int_acc_stream_if.slave   bus
);
    localparam int SH_W   = 1 << EXP_W;
    localparam int WIDE_W = MANT_W + SH_W;
`ifdef ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [EXP_W-1:0]   exp_ref_q, exp_ref_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q, s1_sign_d;
    logic [ACC_W-1:0]   s1_mag_q, s1_mag_d;
    logic               s1_loss_q, s1_loss_d;

    logic               accept_s;
    logic               done_s;
    logic [EXP_W-1:0]   ref_s;
    logic [EXP_W:0]     diff_s;
    logic [EXP_W:0]     neg_s;
    logic [WIDE_W-1:0]  wide_s;
    logic [ACC_W:0]     step_s;

    assign accept_s = bus.in_valid & in_ready_q;
    assign done_s   = out_valid_q & bus.out_ready;

    // Add or subtract one aligned term; returns {overflow, result}.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] m,
                                                input logic             sub);
        logic [ACC_W-1:0] r;
        logic             v;
        if (sub) begin
            r = a - m;
            v = (a[ACC_W-1] != m[ACC_W-1]) && (r[ACC_W-1] != a[ACC_W-1]);
        end else begin
            r = a + m;
            v = (a[ACC_W-1] == m[ACC_W-1]) && (r[ACC_W-1] != a[ACC_W-1]);
        end
`ifdef ACC_SATURATE_EN
        r = v ? (a[ACC_W-1] ? ACC_MIN : ACC_MAX) : r;
`endif
        return {v, r};
    endfunction

    // Batch sequencing: accept terms, wait for the pipeline to empty, hold the result.
    always_comb begin
        state_d   = state_q;
        exp_ref_d = exp_ref_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    exp_ref_d = bus.cfg_exp_set;
                    state_d   = bus.in_last ? ST_DRAIN : ST_ACCUM;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && bus.in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_HOLD);
    end

    // The first beat of a batch aligns against cfg_exp_set before it is latched.
    always_comb begin
        ref_s  = (state_q == ST_IDLE) ? bus.cfg_exp_set : exp_ref_q;
        diff_s = {1'b0, bus.in_exp} - {1'b0, ref_s};
        if (diff_s[EXP_W]) begin
            neg_s  = {(EXP_W+1){1'b0}} - diff_s;
            wide_s = {{SH_W{1'b0}}, bus.in_mant >> neg_s};
        end else begin
            neg_s  = {(EXP_W+1){1'b0}};
            wide_s = {{SH_W{1'b0}}, bus.in_mant} << diff_s[EXP_W-1:0];
        end
        s1_valid_d = accept_s;
        s1_sign_d  = bus.in_sign;
        s1_loss_d  = |wide_s[WIDE_W-1:ACC_W-1];
`ifdef ACC_SATURATE_EN
        s1_mag_d   = s1_loss_d ? ACC_MAX : wide_s[ACC_W-1:0];
`else
        s1_mag_d   = wide_s[ACC_W-1:0];
`endif
    end

    // Accumulate stage, term counter and sticky overflow; cleared on result handshake.
    always_comb begin
        step_s = acc_step(acc_q, s1_mag_q, s1_sign_q);
        if (done_s) begin
            acc_d = {ACC_W{1'b0}};
            ovf_d = 1'b0;
        end else if (s1_valid_q) begin
            acc_d = step_s[ACC_W-1:0];
            ovf_d = ovf_q | s1_loss_q | step_s[ACC_W];
        end else begin
            acc_d = acc_q;
            ovf_d = ovf_q;
        end
        if (done_s) begin
            count_d = {CNT_W{1'b0}};
        end else if (accept_s && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            exp_ref_q   <= {EXP_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            ovf_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= {ACC_W{1'b0}};
            s1_loss_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            exp_ref_q   <= exp_ref_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_loss_q   <= s1_loss_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_exp   = exp_ref_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_fp_int_acc_stream.sv
// Scoreboard bench for fp_int_acc_stream: directed batches push expected results,
// a monitor pops and compares whenever out_valid is presented.
module tb_fp_int_acc_stream;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_edge = 0;
    int   stall_left = 0;

    typedef struct {
        logic [31:0] acc;
        logic [4:0]  exp;
        logic [7:0]  cnt;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fp_int_acc_stream_if #(.MANT_W(14), .EXP_W(5), .ACC_W(32), .CNT_W(8)) bus ();

    fp_int_acc_stream #(.MANT_W(14), .EXP_W(5), .ACC_W(32), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic s, input logic [4:0] e, input logic [13:0] m, input logic l);
        int n;
        @(negedge clk);
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        end else begin
            last_edge = cyc + 1;
            @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [4:0] e, input logic [7:0] c,
                            input logic o);
        exp_t t;
        t.acc = a;
        t.exp = e;
        t.cnt = c;
        t.ovf = o;
        t.lat = last_edge + 2;
        sb.push_back(t);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_in_ready"},  {63'd0, bus.in_ready},  64'd0);
        check({tag, "_out_acc"},   {32'd0, bus.out_acc},   64'd0);
        check({tag, "_out_exp"},   {59'd0, bus.out_exp},   64'd0);
        check({tag, "_out_count"}, {56'd0, bus.out_count}, 64'd0);
        check({tag, "_out_ovf"},   {63'd0, bus.out_ovf},   64'd0);
    endtask

    // Monitor: compare each presented result, then check it stays stable while stalled.
    initial begin : monitor
        exp_t cur;
        logic prev_v;
        prev_v = 1'b0;
        bus.out_ready = 1'b1;
        cur.acc = 32'd0; cur.exp = 5'd0; cur.cnt = 8'd0; cur.ovf = 1'b0; cur.lat = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.out_valid === 1'b1) begin
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("out_acc",   {32'd0, bus.out_acc},   {32'd0, cur.acc});
                        check("out_exp",   {59'd0, bus.out_exp},   {59'd0, cur.exp});
                        check("out_count", {56'd0, bus.out_count}, {56'd0, cur.cnt});
                        check("out_ovf",   {63'd0, bus.out_ovf},   {63'd0, cur.ovf});
                        check("latency",   64'(cyc),               64'(cur.lat));
                    end
                end else begin
                    check("hold_acc",   {32'd0, bus.out_acc},   {32'd0, cur.acc});
                    check("hold_count", {56'd0, bus.out_count}, {56'd0, cur.cnt});
                end
                check("in_ready_in_hold", {63'd0, bus.in_ready}, 64'd0);
                if (stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
                prev_v = 1'b1;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    initial begin : driver
        rst = 1'b0;
        bus.cfg_exp_set = 5'd0;
        bus.in_valid = 1'b0;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 5'd0;
        bus.in_mant  = 14'd0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Mixed shifts; cfg change after the first beat must be ignored.
        bus.cfg_exp_set = 5'd10;
        send(1'b0, 5'd10, 14'd100, 1'b0);
        bus.cfg_exp_set = 5'd3;
        send(1'b0, 5'd12, 14'd3, 1'b0);
        send(1'b1, 5'd8, 14'd40, 1'b1);
        push_exp(32'd102, 5'd10, 8'd1 + 8'd2, 1'b0);

        // Right-shift truncation, and the shift-by-MANT_W boundary.
        bus.cfg_exp_set = 5'd10;
        send(1'b0, 5'd7, 14'd15, 1'b1);
        push_exp(32'd1, 5'd10, 8'd1, 1'b0);
        send(1'b0, 5'd0, 14'h3FFF, 1'b1);
        push_exp(32'd15, 5'd10, 8'd1, 1'b0);
        bus.cfg_exp_set = 5'd14;
        send(1'b0, 5'd0, 14'h3FFF, 1'b1);
        push_exp(32'd0, 5'd14, 8'd1, 1'b0);

        // Shift loss on an oversized term.
        bus.cfg_exp_set = 5'd0;
        send(1'b0, 5'd20, 14'h3FFF, 1'b1);
`ifdef ACC_SATURATE_EN
        push_exp(32'h7FFFFFFF, 5'd0, 8'd1, 1'b1);
`else
        push_exp(32'hFFF00000, 5'd0, 8'd1, 1'b1);
`endif

        // Signed add overflow on the third term.
        bus.cfg_exp_set = 5'd0;
        send(1'b0, 5'd16, 14'h3FFF, 1'b0);
        send(1'b0, 5'd16, 14'h3FFF, 1'b0);
        send(1'b0, 5'd16, 14'h3FFF, 1'b1);
`ifdef ACC_SATURATE_EN
        push_exp(32'h7FFFFFFF, 5'd0, 8'd3, 1'b1);
`else
        push_exp(32'hBFFD0000, 5'd0, 8'd3, 1'b1);
`endif

        // Single negative beat with a stalled consumer.
        bus.cfg_exp_set = 5'd4;
        stall_left = 5;
        send(1'b1, 5'd4, 14'd5, 1'b1);
        push_exp(32'hFFFFFFFB, 5'd4, 8'd1, 1'b0);

        // Zero mantissa is counted but adds nothing; accumulator restarts from 0.
        bus.cfg_exp_set = 5'd5;
        send(1'b0, 5'd5, 14'd0, 1'b0);
        send(1'b0, 5'd5, 14'd9, 1'b1);
        push_exp(32'd9, 5'd5, 8'd2, 1'b0);

        // Reset in the middle of a batch discards it.
        bus.cfg_exp_set = 5'd10;
        send(1'b0, 5'd10, 14'd1, 1'b0);
        send(1'b0, 5'd10, 14'd2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        bus.cfg_exp_set = 5'd3;
        send(1'b0, 5'd3, 14'd7, 1'b1);
        push_exp(32'd7, 5'd3, 8'd1, 1'b0);

        // Long batch: counter saturates at 255, sum does not.
        bus.cfg_exp_set = 5'd0;
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 5'd0, 14'd1, (i == 299) ? 1'b1 : 1'b0);
        end
        push_exp(32'd300, 5'd0, 8'd255, 1'b0);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
